rd_seq_ctrl: RTL and testbench
==============================

RD_SEQ_CTRL -- requirements
Module: rd_seq_ctrl

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 7, address/count width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, read-data width.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port start_i  in  1  job request, sampled only in IDLE.
REQ-006 SHALL have port len_i  in  CNT_WIDTH  number of words in the job, latched on accepted start.
REQ-007 SHALL have port cnt_i  in  CNT_WIDTH  current address from the downstream address counter.
REQ-008 SHALL have port en_o  out  1  counter increment; drives counter en.
REQ-009 SHALL have port cnt_clr_o  out  1  counter clear; drives counter done_i.
REQ-010 SHALL have port rd_en_o / rd_addr_o  out  1 / CNT_WIDTH  memory read strobe and address.
REQ-011 SHALL have port rd_data_i  in  DATA_WIDTH  memory data, valid exactly 1 cycle after rd_en_o.
REQ-012 SHALL have ports out_valid_o, out_data_o (out) and out_ready_i (in), a valid/ready output stream.
REQ-013 SHALL have ports busy_o and done_o  out  1  job active; 1-cycle job-complete pulse.

Function
REQ-014 SHALL implement FSM IDLE, RUN, DRAIN, DONE.
REQ-015 IDLE: start_i=1 and len_i!=0 -> latch len_q, go RUN; start_i=1 and len_i=0 -> go DONE, no reads issued.
REQ-016 SHALL ignore start_i in RUN, DRAIN and DONE.
REQ-017 SHALL hold a 2-entry output FIFO plus an in-flight flag; issue allowed only when occupancy + inflight, minus 1 if the FIFO is popped this cycle, is less than 2.
REQ-018 RUN: on each allowed cycle SHALL assert rd_en_o=1, en_o=1 and rd_addr_o=cnt_i in the same cycle.
REQ-019 SHALL push rd_data_i into the FIFO on the cycle after each rd_en_o; no data is ever dropped.
REQ-020 A read issued at cnt_i = len_q-1 SHALL be the last; FSM goes RUN -> DRAIN on that cycle.
REQ-021 DRAIN: no reads; go DONE when inflight=0 and the FIFO is empty.
REQ-022 DONE lasts exactly 1 cycle with done_o=1, cnt_clr_o=1, en_o=0; then IDLE.
REQ-023 en_o and cnt_clr_o SHALL never both be 1.
REQ-024 busy_o=1 in RUN and DRAIN, 0 in IDLE and DONE.
REQ-025 out_valid_o = FIFO non-empty; out_data_o = FIFO head; pop on out_valid_o and out_ready_i.
REQ-026 Simultaneous push and pop SHALL be legal at any occupancy, and the occupancy SHALL never exceed 2.
REQ-027 Output order SHALL equal issue order (addresses 0..len_q-1 ascending).
REQ-028 Max throughput: 1 word/cycle while out_ready_i is held 1.
REQ-029 len_i = 2^CNT_WIDTH-1 SHALL be supported; cnt_i never wraps within a job.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, FIFO empty, inflight=0, len_q=0.
REQ-031 During and after reset, all outputs SHALL be 0 (busy_o, done_o, en_o, cnt_clr_o, rd_en_o, out_valid_o, rd_addr_o, out_data_o).
REQ-032 Reset mid-job SHALL discard FIFO contents and pending reads; the counter is cleared by its own reset.

Structure
REQ-033 The state enum and its encoding SHALL live in the shared package, as SHALL the default parameter constants.
REQ-034 The 2-entry FIFO SHALL be a sub-module named fifo2_sync, with push/pop/full/empty/count ports.
REQ-035 The downstream address counter SHALL be instantiated at top level, not inside this block.

Verification
REQ-036 Reset, then start_i=1 with len_i=5 and out_ready_i=1 -> rd_addr_o 0,1,2,3,4 on consecutive cycles, 5 outputs, done_o 1 cycle after the last pop, cnt_i=0 after DONE.
REQ-037 Start with len_i=0 -> done_o pulses 1 cycle after start, with no rd_en_o and no out_valid_o.
REQ-038 len_i=8 with out_ready_i=0 -> exactly 2 reads issued, then stall; after releasing ready, all 8 words arrive in order with none lost.
REQ-039 len_i=4 with out_ready_i toggling 1/0 each cycle, and start_i pulsed while busy -> second start ignored, 4 words in order, a single done_o.
REQ-040 Assert rst_n=0 mid-RUN at len_i=10 after 3 issues -> all outputs 0 immediately; a new len_i=2 job then starts from address 0.

Source files
------------

// File: rtl/rd_seq_ctrl_pkg.sv
// Shared definitions for the read-sequencing controller: default widths,
// FSM state encoding and the read-issue admission rule.
package rd_seq_ctrl_pkg;

   localparam int unsigned CNT_WIDTH_DEF  = 7;
   localparam int unsigned DATA_WIDTH_DEF = 32;
   localparam int unsigned FIFO_DEPTH     = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // A new read may be issued only if the word it returns is guaranteed a
   // FIFO slot: stored words plus the word in flight, less any word leaving
   // this cycle, must leave room for one more.
   function automatic logic issue_allowed(input logic [1:0] count,
                                          input logic       inflight,
                                          input logic       pop);
      logic [2:0] load;
      load = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
      return (load < 3'(FIFO_DEPTH));
   endfunction

endpackage

// File: rtl/rd_seq_ctrl_fifo2_sync.sv
// Two-entry synchronous FIFO. Push and pop may coincide at any occupancy;
// a push into a full FIFO only lands when the same cycle also pops.
module fifo2_sync #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   input  logic                  pop_i,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [1:0]            count_o,
   output logic [DATA_WIDTH-1:0] head_o
);

   logic [DATA_WIDTH-1:0] mem_q [2];
   logic                  rd_ptr_q;
   logic                  wr_ptr_q;
   logic [1:0]            count_q;
   logic                  do_pop_s;
   logic                  do_push_s;

   assign do_pop_s  = pop_i & (count_q != 2'd0);
   assign do_push_s = push_i & ((count_q != 2'd2) | do_pop_s);

   // Storage, pointers and occupancy; storage is cleared so the head reads 0 after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= {DATA_WIDTH{1'b0}};
         mem_q[1] <= {DATA_WIDTH{1'b0}};
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (do_pop_s) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_q + {1'b0, do_push_s} - {1'b0, do_pop_s};
      end
   end

   assign full_o  = (count_q == 2'd2);
   assign empty_o = (count_q == 2'd0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/rd_seq_ctrl.sv
// Read-sequencing controller: walks addresses 0..len-1 of a memory using an
// external address counter, buffers returned words in a 2-entry FIFO and
// streams them out over valid/ready, with backpressure throttling reads.
module rd_seq_ctrl
   import rd_seq_ctrl_pkg::*;
#(
   parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF,
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic [CNT_WIDTH-1:0]  len_i,
   input  logic [CNT_WIDTH-1:0]  cnt_i,
   output logic                  en_o,
   output logic                  cnt_clr_o,
   output logic                  rd_en_o,
   output logic [CNT_WIDTH-1:0]  rd_addr_o,
   input  logic [DATA_WIDTH-1:0] rd_data_i,
   output logic                  out_valid_o,
   output logic [DATA_WIDTH-1:0] out_data_o,
   input  logic                  out_ready_i,
   output logic                  busy_o,
   output logic                  done_o
);

   state_e                state_q, state_d;
   logic [CNT_WIDTH-1:0]  len_q, len_d;
   logic                  inflight_q, inflight_d;
   logic                  issue_s;
   logic                  issue_ok_s;
   logic [CNT_WIDTH-1:0]  rd_addr_s;
   logic                  pop_s;
   logic                  fifo_full_s;
   logic                  fifo_empty_s;
   logic [1:0]            fifo_count_s;
   logic [CNT_WIDTH-1:0]  last_addr_s;

   assign pop_s       = ~fifo_empty_s & out_ready_i;
   assign last_addr_s = len_q - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   assign issue_ok_s  = issue_allowed(fifo_count_s, inflight_q, pop_s)
                        & ~(fifo_full_s & ~pop_s);

   // State, latched job length and the one-deep in-flight read marker.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         len_q      <= {CNT_WIDTH{1'b0}};
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         inflight_q <= inflight_d;
      end
   end

   // Next-state and read-issue decisions.
   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      issue_s   = 1'b0;
      rd_addr_s = {CNT_WIDTH{1'b0}};
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               if (len_i != {CNT_WIDTH{1'b0}}) begin
                  len_d   = len_i;
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_DONE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (issue_ok_s) begin
               issue_s   = 1'b1;
               rd_addr_s = cnt_i;
               if (cnt_i == last_addr_s) begin
                  state_d = ST_DRAIN;
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DRAIN: begin
            // Leave once the FIFO will be empty after this cycle's pop.
            if (!inflight_q && (fifo_empty_s || ((fifo_count_s == 2'd1) && pop_s))) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign inflight_d = issue_s;

   fifo2_sync #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (inflight_q),
      .push_data_i (rd_data_i),
      .pop_i       (pop_s),
      .full_o      (fifo_full_s),
      .empty_o     (fifo_empty_s),
      .count_o     (fifo_count_s),
      .head_o      (out_data_o)
   );

   assign rd_en_o     = issue_s;
   assign en_o        = issue_s;
   assign rd_addr_o   = rd_addr_s;
   assign out_valid_o = ~fifo_empty_s;
   assign busy_o      = (state_q == ST_RUN) | (state_q == ST_DRAIN);
   assign done_o      = (state_q == ST_DONE);
   assign cnt_clr_o   = (state_q == ST_DONE);

endmodule

// File: tb/tb_rd_seq_ctrl.sv
// Self-checking bench for rd_seq_ctrl: provides the downstream address
// counter and a 1-cycle-latency memory, drives jobs with varied output
// backpressure and compares every cycle against a count-based job model.
module tb_rd_seq_ctrl;

   localparam int CW = 7;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start_i = 1'b0;
   logic [CW-1:0] len_i = '0;
   logic [CW-1:0] cnt_q;
   logic          en_o, cnt_clr_o, rd_en_o;
   logic [CW-1:0] rd_addr_o;
   logic [DW-1:0] rd_data_q;
   logic          out_valid_o;
   logic [DW-1:0] out_data_o;
   logic          out_ready_i = 1'b0;
   logic          busy_o, done_o;

   int n_checks = 0;
   int n_errors = 0;
   int ready_mode = 0;   // 0: ready held 1, 1: held 0, 2: toggle, 3: random

   // model state
   int m_phase = 0;      // 0 idle, 1 job active, 2 done pulse
   int m_len = 0, m_issued = 0, m_pushed = 0, m_popped = 0;
   bit m_inflight = 1'b0;

   // observed statistics
   int cyc = 0;
   int n_issue = 0, n_pop = 0, n_done = 0;
   int first_issue_cyc = 0, last_issue_cyc = 0, last_pop_cyc = 0, done_cyc = 0, accept_cyc = 0;

   always #5 clk = ~clk;

   rd_seq_ctrl #(.CNT_WIDTH(CW), .DATA_WIDTH(DW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start_i),
      .len_i       (len_i),
      .cnt_i       (cnt_q),
      .en_o        (en_o),
      .cnt_clr_o   (cnt_clr_o),
      .rd_en_o     (rd_en_o),
      .rd_addr_o   (rd_addr_o),
      .rd_data_i   (rd_data_q),
      .out_valid_o (out_valid_o),
      .out_data_o  (out_data_o),
      .out_ready_i (out_ready_i),
      .busy_o      (busy_o),
      .done_o      (done_o)
   );

   function automatic logic [DW-1:0] data_of(input int a);
      logic [31:0] x;
      x = 32'h9E37_79B9 * (32'(a) + 32'd1);
      return x ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // downstream address counter
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)         cnt_q <= '0;
      else if (cnt_clr_o) cnt_q <= '0;
      else if (en_o)      cnt_q <= cnt_q + 1'b1;
   end

   // memory with one cycle read latency
   always @(posedge clk) begin
      rd_data_q <= rd_en_o ? data_of(int'(rd_addr_o)) : '0;
   end

   // output backpressure driver
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       out_ready_i = 1'b1;
         1:       out_ready_i = 1'b0;
         2:       out_ready_i = ~out_ready_i;
         default: out_ready_i = 1'($urandom_range(0, 1));
      endcase
   end

   // per-cycle compare against the job model, then advance the model
   always @(negedge clk) begin
      bit exp_valid, pop_m, exp_issue, exp_busy, exp_done;
      int occ;
      cyc++;
      if (!rst_n) begin
         m_phase = 0; m_len = 0; m_issued = 0; m_pushed = 0; m_popped = 0; m_inflight = 1'b0;
         chk("rst_ctrl_outs", 64'({busy_o, done_o, en_o, cnt_clr_o, rd_en_o, out_valid_o}), 64'd0);
         chk("rst_rd_addr", 64'(rd_addr_o), 64'd0);
         chk("rst_out_data", 64'(out_data_o), 64'd0);
      end else begin
         exp_valid = (m_pushed > m_popped);
         pop_m     = exp_valid && out_ready_i;
         occ       = (m_pushed - m_popped) + int'(m_inflight) - int'(pop_m);
         exp_issue = (m_phase == 1) && (m_issued < m_len) && (occ < 2);
         exp_busy  = (m_phase == 1);
         exp_done  = (m_phase == 2);
         chk("rd_en", 64'(rd_en_o), 64'(exp_issue));
         chk("en", 64'(en_o), 64'(exp_issue));
         chk("rd_addr", 64'(rd_addr_o), exp_issue ? 64'(m_issued) : 64'd0);
         chk("out_valid", 64'(out_valid_o), 64'(exp_valid));
         if (exp_valid) chk("out_data", 64'(out_data_o), 64'(data_of(m_popped)));
         chk("busy", 64'(busy_o), 64'(exp_busy));
         chk("done", 64'(done_o), 64'(exp_done));
         chk("cnt_clr", 64'(cnt_clr_o), 64'(exp_done));
         chk("en_clr_excl", 64'(en_o & cnt_clr_o), 64'd0);

         if (rd_en_o) begin
            n_issue++;
            last_issue_cyc = cyc;
            if (rd_addr_o == '0) first_issue_cyc = cyc;
         end
         if (out_valid_o && out_ready_i) begin
            n_pop++;
            last_pop_cyc = cyc;
         end
         if (done_o) begin
            n_done++;
            done_cyc = cyc;
         end

         case (m_phase)
            0: if (start_i) begin
                  accept_cyc = cyc;
                  if (len_i == '0) m_phase = 2;
                  else begin
                     m_phase = 1; m_len = int'(len_i);
                     m_issued = 0; m_pushed = 0; m_popped = 0; m_inflight = 1'b0;
                  end
               end
            1: begin
                  if (m_inflight) m_pushed++;
                  if (pop_m) m_popped++;
                  if (exp_issue) m_issued++;
                  m_inflight = exp_issue;
                  if (m_popped == m_len) m_phase = 2;
               end
            default: m_phase = 0;
         endcase
      end
   end

   task automatic do_start(input int len);
      @(posedge clk); #1;
      start_i = 1'b1;
      len_i   = CW'(len);
      @(posedge clk); #1;
      start_i = 1'b0;
      len_i   = CW'($urandom);
   endtask

   task automatic stray_start();
      @(posedge clk); #1;
      start_i = 1'b1;
      len_i   = CW'($urandom_range(1, 100));
      @(posedge clk); #1;
      start_i = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int bound, input string nm);
      bit got;
      got = 1'b0;
      for (int k = 0; k < bound; k++) begin
         @(posedge clk);
         if (n_done != d0) begin
            got = 1'b1;
            break;
         end
      end
      chk(nm, 64'(got), 64'd1);
   endtask

   initial begin
      int i0, p0, d0, len, m;
      bit got;

      // reset
      ready_mode = 0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // len 5, ready held high
      i0 = n_issue; p0 = n_pop; d0 = n_done;
      do_start(5);
      wait_done(d0, 50, "t1_done_seen");
      chk("t1_issues", 64'(n_issue - i0), 64'd5);
      chk("t1_pops", 64'(n_pop - p0), 64'd5);
      chk("t1_issue_span", 64'(last_issue_cyc - first_issue_cyc), 64'd4);
      chk("t1_done_gap", 64'(done_cyc - last_pop_cyc), 64'd1);
      #2 chk("t1_cnt_cleared", 64'(cnt_q), 64'd0);

      // zero-length job
      i0 = n_issue; p0 = n_pop; d0 = n_done;
      do_start(0);
      wait_done(d0, 10, "t2_done_seen");
      chk("t2_done_gap", 64'(done_cyc - accept_cyc), 64'd1);
      chk("t2_issues", 64'(n_issue - i0), 64'd0);
      chk("t2_pops", 64'(n_pop - p0), 64'd0);

      // len 8 with output stalled
      ready_mode = 1;
      i0 = n_issue; p0 = n_pop; d0 = n_done;
      do_start(8);
      repeat (20) @(posedge clk);
      chk("t3_stall_issues", 64'(n_issue - i0), 64'd2);
      ready_mode = 0;
      wait_done(d0, 60, "t3_done_seen");
      chk("t3_pops", 64'(n_pop - p0), 64'd8);

      // len 4, toggling ready, stray start while busy
      ready_mode = 2;
      p0 = n_pop; d0 = n_done;
      do_start(4);
      stray_start();
      wait_done(d0, 60, "t4_done_seen");
      repeat (6) @(posedge clk);
      chk("t4_single_done", 64'(n_done - d0), 64'd1);
      chk("t4_pops", 64'(n_pop - p0), 64'd4);

      // reset in the middle of a len 10 job
      ready_mode = 0;
      i0 = n_issue; d0 = n_done;
      do_start(10);
      got = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         if (n_issue - i0 >= 3) begin
            got = 1'b1;
            break;
         end
      end
      chk("t5_reached_3_issues", 64'(got), 64'd1);
      #3 rst_n = 1'b0;
      #1;
      chk("t5_ctrl_outs_zero", 64'({busy_o, done_o, en_o, cnt_clr_o, rd_en_o, out_valid_o}), 64'd0);
      chk("t5_rd_addr_zero", 64'(rd_addr_o), 64'd0);
      chk("t5_out_data_zero", 64'(out_data_o), 64'd0);
      chk("t5_no_done_before_rst", 64'(n_done - d0), 64'd0);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      p0 = n_pop; d0 = n_done;
      do_start(2);
      wait_done(d0, 40, "t5_done_seen");
      chk("t5_pops", 64'(n_pop - p0), 64'd2);

      // randomized jobs, ending with the maximum length
      for (int j = 0; j < 30; j++) begin
         len = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 14));
         m   = int'($urandom_range(0, 2));
         ready_mode = (m == 0) ? 0 : m + 1;
         if (j == 29) begin
            len = (1 << CW) - 1;
            ready_mode = 0;
         end
         p0 = n_pop; d0 = n_done;
         do_start(len);
         if (len != 0 && $urandom_range(0, 1) == 1) stray_start();
         wait_done(d0, 4 * len + 40, "rnd_done_seen");
         chk("rnd_pops", 64'(n_pop - p0), 64'(len));
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
